// File: rtl/coax_rx_buffer.sv
// rtl/coax_rx_buffer.sv - show-ahead receive FIFO with frame/error tracking for the coax receiver
//
// Purpose: queues 10-bit words from the coax receiver for the host side, pulses
// frame_done when a frame closes cleanly, and holds sticky error/overflow flags
// until clear.
//
// Optional feature: define COAX_RX_BUFFER_DISCARD_ON_ERROR_EN to drop the words of
// a frame that is aborted by rx_error (those not yet popped by the host).
//
// Ports:
//   clk, reset         clock; asynchronous active-high reset
//   clear              synchronous clear of FIFO, flags and frame tracking
//   rx_active          receiver has a frame in progress
//   rx_error, rx_data  receiver error flag; rx_data carries the error code while high
//   rx_strobe          rx_data is a received word this cycle
//   read_strobe        host pops the head word
//   data               head word, valid while !empty
//   empty, full, depth FIFO occupancy (depth = 0..DEPTH)
//   frame_done         one-cycle pulse at a clean end of frame
//   error, error_code  sticky error and the code seen on the first error
//   overflow           sticky: a word was dropped because the FIFO was full

module coax_rx_buffer #(
  parameter int DEPTH = 16,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              rx_active,
  input  logic              rx_error,
  input  logic [9:0]        rx_data,
  input  logic              rx_strobe,
  input  logic              read_strobe,
  output logic [9:0]        data,
  output logic              empty,
  output logic              full,
  output logic [ADDR_W:0]   depth,
  output logic              frame_done,
  output logic              error,
  output logic [9:0]        error_code,
  output logic              overflow
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FRAME = 2'd1;
  localparam logic [1:0] ST_ERROR = 2'd2;

  localparam logic [ADDR_W:0] DEPTH_V = (ADDR_W + 1)'(DEPTH);

  logic [9:0]        mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   depth_q, depth_d;
  logic [ADDR_W:0]   frame_written_q, frame_written_d;
  logic [1:0]        state_q, state_d;
  logic [9:0]        data_q, data_d;
  logic [9:0]        error_code_q, error_code_d;
  logic              frame_done_q, frame_done_d;
  logic              error_q, error_d;
  logic              overflow_q, overflow_d;

  logic              full_w, empty_w;
  logic              wr_en, rd_en, wr_take, err_entry;
  logic [ADDR_W:0]   rewind;

  assign full_w    = (depth_q == DEPTH_V);
  assign empty_w   = (depth_q == '0);
  assign wr_en     = rx_strobe && (!full_w || read_strobe);
  assign rd_en     = read_strobe && !empty_w;
  assign err_entry = rx_error && (state_q != ST_ERROR);

`ifdef COAX_RX_BUFFER_DISCARD_ON_ERROR_EN
  logic            discard;
  logic [ADDR_W:0] avail;

  // Only the newest frame words still in the FIFO can be recalled; a word popped
  // this same cycle is already gone, so it is excluded from what can be rewound.
  assign discard = err_entry && (state_q == ST_FRAME);
  assign avail   = depth_q - (ADDR_W + 1)'(rd_en);
  assign rewind  = !discard ? '0 :
                   (frame_written_q < avail) ? frame_written_q : avail;
  assign wr_take = wr_en && !discard;
`else
  assign rewind  = '0;
  assign wr_take = wr_en;
`endif

  always_comb begin
    wr_ptr_d        = wr_ptr_q + ADDR_W'(wr_take) - rewind[ADDR_W-1:0];
    rd_ptr_d        = rd_ptr_q + ADDR_W'(rd_en);
    depth_d         = depth_q + (ADDR_W + 1)'(wr_take) - (ADDR_W + 1)'(rd_en) - rewind;
    frame_written_d = frame_written_q;
    state_d         = state_q;
    data_d          = data_q;
    error_code_d    = error_code_q;
    frame_done_d    = 1'b0;
    error_d         = error_q;
    overflow_d      = overflow_q;

    // The head only changes on a pop or on a write into an empty FIFO; a word
    // landing at the new head slot is bypassed because mem_q updates at the edge.
    if (rd_en || wr_take) begin
      if (wr_take && (wr_ptr_q == rd_ptr_d)) begin
        data_d = rx_data;
      end else begin
        data_d = mem_q[rd_ptr_d];
      end
    end

    if (rx_strobe && full_w && !read_strobe) begin
      overflow_d = 1'b1;
    end

    if (err_entry) begin
      state_d = ST_ERROR;
      error_d = 1'b1;
      // Keep the code of the first error until the host clears it.
      if (!error_q) begin
        error_code_d = rx_data;
      end
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (rx_active) begin
            state_d         = ST_FRAME;
            frame_written_d = '0;
          end
        end
        ST_FRAME: begin
          if (wr_take && (frame_written_q != DEPTH_V)) begin
            frame_written_d = frame_written_q + 1'b1;
          end
          if (!rx_active) begin
            state_d      = ST_IDLE;
            frame_done_d = 1'b1;
          end
        end
        ST_ERROR: begin
          if (!rx_error && !rx_active) begin
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    if (clear) begin
      wr_ptr_d        = '0;
      rd_ptr_d        = '0;
      depth_d         = '0;
      frame_written_d = '0;
      state_d         = ST_IDLE;
      data_d          = data_q;
      error_code_d    = '0;
      frame_done_d    = 1'b0;
      error_d         = 1'b0;
      overflow_d      = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      depth_q         <= '0;
      frame_written_q <= '0;
      state_q         <= ST_IDLE;
      data_q          <= '0;
      error_code_q    <= '0;
      frame_done_q    <= 1'b0;
      error_q         <= 1'b0;
      overflow_q      <= 1'b0;
    end else begin
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      depth_q         <= depth_d;
      frame_written_q <= frame_written_d;
      state_q         <= state_d;
      data_q          <= data_d;
      error_code_q    <= error_code_d;
      frame_done_q    <= frame_done_d;
      error_q         <= error_d;
      overflow_q      <= overflow_d;
    end
  end

  // Storage array has no reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (wr_take && !clear) begin
      mem_q[wr_ptr_q] <= rx_data;
    end
  end

  assign data       = data_q;
  assign empty      = empty_w;
  assign full       = full_w;
  assign depth      = depth_q;
  assign frame_done = frame_done_q;
  assign error      = error_q;
  assign error_code = error_code_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_coax_rx_buffer.sv
// tb/tb_coax_rx_buffer.sv - scoreboard bench for coax_rx_buffer

module tb_coax_rx_buffer;

  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       reset, clear, rx_active, rx_error, rx_strobe, read_strobe;
  logic [9:0] rx_data;
  logic [9:0] data, error_code;
  logic       empty, full, frame_done, error, overflow;
  logic [4:0] depth;

  coax_rx_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .clear(clear),
    .rx_active(rx_active), .rx_error(rx_error), .rx_data(rx_data),
    .rx_strobe(rx_strobe), .read_strobe(read_strobe),
    .data(data), .empty(empty), .full(full), .depth(depth),
    .frame_done(frame_done), .error(error), .error_code(error_code),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: the FIFO is a plain queue; frame mode is 0 idle, 1 frame, 2 error.
  int mq[$];
  int exp_q[$];
  int m_mode, m_fw, m_err, m_code, m_ovf, m_fd;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_mode = 0; m_fw = 0; m_err = 0; m_code = 0; m_ovf = 0; m_fd = 0;
  endtask

  task automatic model_step(input bit clr, input bit act, input bit err,
                            input bit stb, input int din, input bit rd);
    int  sz;
    bit  popped, acc, enter, disc;
    sz     = mq.size();
    popped = rd && (sz > 0);
    acc    = stb && ((sz < DEPTH) || rd);
    enter  = err && (m_mode != 2);
    disc   = 1'b0;
`ifdef COAX_RX_BUFFER_DISCARD_ON_ERROR_EN
    disc   = enter && (m_mode == 1);
`endif
    m_fd = 0;
    if (clr) begin
      model_reset();
    end else begin
      if (popped) exp_q.push_back(mq.pop_front());
      if (acc && !disc) mq.push_back(din);
      if (stb && (sz == DEPTH) && !rd) m_ovf = 1;
      if (enter) begin
        if (disc) begin
          int n;
          n = (m_fw < mq.size()) ? m_fw : mq.size();
          repeat (n) void'(mq.pop_back());
        end
        if (!m_err) m_code = din;
        m_err  = 1;
        m_mode = 2;
      end else if (m_mode == 0) begin
        if (act) begin
          m_mode = 1;
          m_fw   = 0;
        end
      end else if (m_mode == 1) begin
        if (acc && m_fw < DEPTH) m_fw++;
        if (!act) begin
          m_mode = 0;
          m_fd   = 1;
        end
      end else begin
        if (!err && !act) m_mode = 0;
      end
    end
  endtask

  task automatic check_outputs();
    chk("depth", int'(depth), mq.size());
    chk("empty", int'(empty), (mq.size() == 0) ? 1 : 0);
    chk("full", int'(full), (mq.size() == DEPTH) ? 1 : 0);
    chk("error", int'(error), m_err);
    chk("error_code", int'(error_code), m_code);
    chk("overflow", int'(overflow), m_ovf);
    chk("frame_done", int'(frame_done), m_fd);
  endtask

  // One clock: drive inputs just after an edge, advance the model, check after the next edge.
  task automatic cyc(input bit clr, input bit act, input bit err,
                     input bit stb, input int din, input bit rd);
    clear       = clr;
    rx_active   = act;
    rx_error    = err;
    rx_strobe   = stb;
    rx_data     = 10'(din);
    read_strobe = rd;
    model_step(clr, act, err, stb, din & 'h3ff, rd);
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  // Monitor: every accepted pop presents a head word that must match the scoreboard.
  always @(negedge clk) begin
    if (reset === 1'b0 && clear === 1'b0 && read_strobe === 1'b1 && empty === 1'b0) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pop_data: got 0x%0h but no word expected", data);
      end else begin
        chk("pop_data", int'(data), exp_q.pop_front());
      end
    end
  end

  initial begin
    reset = 1'b1; clear = 1'b0; rx_active = 1'b0; rx_error = 1'b0;
    rx_strobe = 1'b0; read_strobe = 1'b0; rx_data = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_data", int'(data), 0);
    check_outputs();
    reset = 1'b0;

    // Frame of three words, clean end, then drain.
    cyc(0, 1, 0, 0, 0, 0);
    cyc(0, 1, 0, 1, 'h155, 0);
    cyc(0, 1, 0, 1, 'h2AA, 0);
    cyc(0, 1, 0, 1, 'h001, 0);
    cyc(0, 0, 0, 0, 0, 0);
    chk("t1_frame_done", int'(frame_done), 1);
    cyc(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 1);
    chk("t1_empty", int'(empty), 1);

    // Seventeen writes, no pops: one dropped; drain all sixteen; clear.
    for (int i = 0; i < 17; i++) cyc(0, 0, 0, 1, 'h100 + i, 0);
    chk("t2_overflow", int'(overflow), 1);
    chk("t2_depth", int'(depth), 16);
    for (int i = 0; i < 16; i++) cyc(0, 0, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 0, 0);
    chk("t2_clear_ovf", int'(overflow), 0);

    // Full FIFO with simultaneous write and pop.
    for (int i = 0; i < 16; i++) cyc(0, 0, 0, 1, 'h200 + i, 0);
    cyc(0, 0, 0, 1, 'h3FF, 1);
    chk("t3_depth", int'(depth), 16);
    chk("t3_overflow", int'(overflow), 0);
    for (int i = 0; i < 16; i++) cyc(0, 0, 0, 0, 0, 1);

    // Frame aborted by an error, then a second error while still in ERROR.
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0);
    cyc(0, 1, 0, 1, 'h0A1, 0);
    cyc(0, 1, 0, 1, 'h0A2, 0);
    cyc(0, 1, 1, 0, 'h002, 0);
    chk("t4_error", int'(error), 1);
    chk("t4_code", int'(error_code), 'h002);
`ifdef COAX_RX_BUFFER_DISCARD_ON_ERROR_EN
    chk("t4_depth", int'(depth), 0);
`else
    chk("t4_depth", int'(depth), 2);
`endif
    cyc(0, 1, 1, 0, 'h001, 0);
    cyc(0, 0, 0, 0, 0, 0);
    chk("t5_code", int'(error_code), 'h002);
    cyc(0, 0, 0, 0, 0, 0);
    chk("t4_no_frame_done", int'(frame_done), 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 1);

    // Asynchronous reset in the middle of a five-word frame.
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) cyc(0, 1, 0, 1, 'h050 + i, 0);
    chk("t6_pre_depth", int'(depth), 5);
    #2;
    reset = 1'b1;
    #1;
    chk("t6_depth", int'(depth), 0);
    chk("t6_empty", int'(empty), 1);
    chk("t6_data", int'(data), 0);
    chk("t6_full", int'(full), 0);
    chk("t6_error", int'(error), 0);
    chk("t6_overflow", int'(overflow), 0);
    rx_active = 1'b0; rx_strobe = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 0);

    // Randomized traffic.
    begin
      bit act;
      int rd_bias;
      act = 1'b0;
      rd_bias = 2;
      for (int i = 0; i < 3000; i++) begin
        if (i % 250 == 0) rd_bias = $urandom_range(1, 5);
        if ($urandom_range(0, 7) == 0) act = ~act;
        cyc(($urandom_range(0, 299) == 0),
            act,
            ($urandom_range(0, 39) == 0),
            $urandom_range(0, 1),
            $urandom_range(0, 1023),
            ($urandom_range(0, rd_bias) == 0));
      end
    end

    for (int i = 0; i < DEPTH + 2; i++) cyc(0, 0, 0, 0, 0, 1);
    chk("scoreboard_left", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
